// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } sram_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         PERF_W   = 16;

  // Saturating increment used by the performance counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value,
                                                input logic              en);
    return (en && (value != '1)) ? value + 1'b1 : value;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares the ID-stage source registers against one later stage's destination.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic [4:0] dest_src,
  input  logic       two_src,
  input  logic       uses_dest,
  input  logic [4:0] stage_dest,
  input  logic       stage_wb,
  output logic       match
);

  // A zero stage destination can never match, which also covers zero sources.
  assign match = stage_wb && (stage_dest != REG_ZERO) &&
                 ((src1 == stage_dest) ||
                  (two_src && (src2 == stage_dest)) ||
                  (uses_dest && (dest_src == stage_dest)));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline advance/hold/bubble/flush control with the MEM-stage SRAM handshake.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned SRAM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              forward_en_cfg,
  input  logic [4:0]        id_src1,
  input  logic [4:0]        id_src2,
  input  logic [4:0]        id_reg_dest,
  input  logic              id_two_src,
  input  logic              id_is_store,
  input  logic              id_is_bne,
  input  logic [4:0]        exe_reg_dest,
  input  logic              exe_reg_wb,
  input  logic              exe_mem_read,
  input  logic [4:0]        mem_reg_dest,
  input  logic              mem_reg_wb,
  input  logic              mem_access,
  input  logic              sram_ready,
  input  logic              branch_taken,
  output logic              forward_en,
  output logic              pc_freeze,
  output logic              if_id_freeze,
  output logic              id_exe_bubble,
  output logic              exe_mem_freeze,
  output logic              mem_wb_freeze,
  output logic              if_id_flush,
  output logic              sram_req,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(SRAM_TIMEOUT);

  sram_state_e state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic [8:0]  wait_cnt_inc;
  logic        timeout_set;
  logic        sram_freeze;
  logic        exe_match, mem_match;
  logic        hz;

  hazard_match u_match_exe (
    .src1       (id_src1),
    .src2       (id_src2),
    .dest_src   (id_reg_dest),
    .two_src    (id_two_src),
    .uses_dest  (id_is_store | id_is_bne),
    .stage_dest (exe_reg_dest),
    .stage_wb   (exe_reg_wb),
    .match      (exe_match)
  );

  hazard_match u_match_mem (
    .src1       (id_src1),
    .src2       (id_src2),
    .dest_src   (id_reg_dest),
    .two_src    (id_two_src),
    .uses_dest  (id_is_store | id_is_bne),
    .stage_dest (mem_reg_dest),
    .stage_wb   (mem_reg_wb),
    .match      (mem_match)
  );

  assign hz = forward_en_cfg ? (exe_match & exe_mem_read) : (exe_match | mem_match);

  assign wait_cnt_inc = {1'b0, wait_cnt} + 9'd1;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_next    = state;
    wait_cnt_next = wait_cnt;
    sram_freeze   = 1'b0;
    timeout_set   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Gating with rst_n keeps the request low while reset is held.
        if (rst_n && mem_access) begin
          sram_freeze   = 1'b1;
          wait_cnt_next = '0;
          state_next    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        sram_freeze   = 1'b1;
        wait_cnt_next = wait_cnt_inc[7:0];
        if (sram_ready) begin
          state_next = ST_RELEASE;
        end else if (wait_cnt_inc == TIMEOUT_LIM) begin
          timeout_set = 1'b1;
          state_next  = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      mem_timeout <= mem_timeout | timeout_set;
    end
  end

  // The SRAM freeze wins over the hazard bubble; both block the branch flush.
  assign forward_en     = forward_en_cfg;
  assign sram_req       = sram_freeze;
  assign pc_freeze      = hz | sram_freeze;
  assign if_id_freeze   = hz | sram_freeze;
  assign id_exe_bubble  = hz & ~sram_freeze;
  assign exe_mem_freeze = sram_freeze;
  assign mem_wb_freeze  = sram_freeze;
  assign if_id_flush    = branch_taken & ~hz & ~sram_freeze;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= sat_inc(stall_cycles,
                              pc_freeze | if_id_freeze | exe_mem_freeze | mem_wb_freeze);
      flush_count  <= sat_inc(flush_count, if_id_flush);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: the driver queues hand-computed control vectors, a monitor compares each cycle.
module tb_hazard_stall_controller;
  import hazard_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              forward_en_cfg;
  logic [4:0]        id_src1, id_src2, id_reg_dest;
  logic              id_two_src, id_is_store, id_is_bne;
  logic [4:0]        exe_reg_dest;
  logic              exe_reg_wb, exe_mem_read;
  logic [4:0]        mem_reg_dest;
  logic              mem_reg_wb, mem_access, sram_ready, branch_taken;
  logic              forward_en, pc_freeze, if_id_freeze, id_exe_bubble;
  logic              exe_mem_freeze, mem_wb_freeze, if_id_flush, sram_req, mem_timeout;
  logic [PERF_W-1:0] stall_cycles, flush_count;

  typedef struct {
    string      name;
    logic [8:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_to;
  int   model_stall, model_flush;

  always #5 clk = ~clk;

  hazard_stall_controller #(.SRAM_TIMEOUT(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .forward_en_cfg (forward_en_cfg),
    .id_src1        (id_src1),
    .id_src2        (id_src2),
    .id_reg_dest    (id_reg_dest),
    .id_two_src     (id_two_src),
    .id_is_store    (id_is_store),
    .id_is_bne      (id_is_bne),
    .exe_reg_dest   (exe_reg_dest),
    .exe_reg_wb     (exe_reg_wb),
    .exe_mem_read   (exe_mem_read),
    .mem_reg_dest   (mem_reg_dest),
    .mem_reg_wb     (mem_reg_wb),
    .mem_access     (mem_access),
    .sram_ready     (sram_ready),
    .branch_taken   (branch_taken),
    .forward_en     (forward_en),
    .pc_freeze      (pc_freeze),
    .if_id_freeze   (if_id_freeze),
    .id_exe_bubble  (id_exe_bubble),
    .exe_mem_freeze (exe_mem_freeze),
    .mem_wb_freeze  (mem_wb_freeze),
    .if_id_flush    (if_id_flush),
    .sram_req       (sram_req),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Vector layout: {fwd, pc, if_id, bubble, exe_mem, mem_wb, flush, req, timeout}
  function automatic logic [8:0] mk(input logic hz, input logic frz, input logic fl);
    return {forward_en_cfg, hz | frz, hz | frz, hz & ~frz, frz, frz, fl, frz, exp_to};
  endfunction

  task automatic step(input string name, input logic [8:0] e);
    exp_t item;
    item.name = name;
    item.vec  = e;
    sb.push_back(item);
    if (rst_n) begin
      if (e[7] | e[6] | e[4] | e[3]) model_stall++;
      if (e[2]) model_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_src1 = 5'd0; id_src2 = 5'd0; id_reg_dest = 5'd0;
    id_two_src = 1'b0; id_is_store = 1'b0; id_is_bne = 1'b0;
    exe_reg_dest = 5'd0; exe_reg_wb = 1'b0; exe_mem_read = 1'b0;
    mem_reg_dest = 5'd0; mem_reg_wb = 1'b0;
    mem_access = 1'b0; sram_ready = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic load_use_on();
    id_src1 = 5'd5; exe_reg_dest = 5'd5; exe_reg_wb = 1'b1; exe_mem_read = 1'b1;
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(model_stall));
    check({tag, "_flush_count"},  32'(flush_count),  32'(model_flush));
`else
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd0);
    check({tag, "_flush_count"},  32'(flush_count),  32'd0);
`endif
  endtask

  // Monitor: the controller presents a full control vector every cycle.
  initial begin
    exp_t item;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        check(item.name,
              {23'd0, forward_en, pc_freeze, if_id_freeze, id_exe_bubble,
               exe_mem_freeze, mem_wb_freeze, if_id_flush, sram_req, mem_timeout},
              {23'd0, item.vec});
      end
    end
  end

  initial begin
    rst_n = 1'b0; forward_en_cfg = 1'b1; exp_to = 1'b0;
    model_stall = 0; model_flush = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    step("reset", mk(0, 0, 0));
    rst_n = 1'b1;
    step("idle", mk(0, 0, 0));

    // Forwarding on: load-use for exactly one cycle, then the load is in MEM.
    load_use_on();
    step("load_use", mk(1, 0, 0));
    idle_inputs(); id_src1 = 5'd5; mem_reg_dest = 5'd5; mem_reg_wb = 1'b1;
    step("load_moved", mk(0, 0, 0));
    idle_inputs(); id_src1 = 5'd5; exe_reg_dest = 5'd5; exe_reg_wb = 1'b1;
    step("fwd_exe_no_load", mk(0, 0, 0));
    idle_inputs(); id_is_store = 1'b1; id_reg_dest = 5'd9;
    exe_reg_dest = 5'd9; exe_reg_wb = 1'b1; exe_mem_read = 1'b1;
    step("store_src", mk(1, 0, 0));
    id_is_store = 1'b0;
    step("dest_not_src", mk(0, 0, 0));
    id_is_bne = 1'b1;
    step("bne_src", mk(1, 0, 0));
    idle_inputs(); id_src2 = 5'd9; exe_reg_dest = 5'd9; exe_reg_wb = 1'b1; exe_mem_read = 1'b1;
    step("src2_unused", mk(0, 0, 0));
    idle_inputs(); load_use_on(); exe_reg_wb = 1'b0;
    step("load_wb_off", mk(0, 0, 0));

    // Forwarding off: any EXE or MEM producer stalls, register 0 never does.
    forward_en_cfg = 1'b0;
    idle_inputs(); id_src2 = 5'd7; id_two_src = 1'b1; mem_reg_dest = 5'd7; mem_reg_wb = 1'b1;
    step("nofwd_mem_src2", mk(1, 0, 0));
    idle_inputs(); id_src1 = 5'd4; exe_reg_dest = 5'd4; exe_reg_wb = 1'b1;
    step("nofwd_exe", mk(1, 0, 0));
    idle_inputs(); exe_reg_wb = 1'b1; id_src2 = 5'd3; id_two_src = 1'b1;
    mem_reg_dest = 5'd6; mem_reg_wb = 1'b1;
    step("nofwd_zero", mk(0, 0, 0));
    forward_en_cfg = 1'b1;

    // SRAM access with ready in the third WAIT cycle, hazard present throughout.
    idle_inputs(); sram_ready = 1'b1;
    step("ready_idle_ignored", mk(0, 0, 0));
    idle_inputs(); load_use_on(); mem_access = 1'b1;
    step("sram_issue", mk(1, 1, 0));
    mem_access = 1'b0;
    step("sram_wait1", mk(1, 1, 0));
    step("sram_wait2", mk(1, 1, 0));
    sram_ready = 1'b1;
    step("sram_wait3", mk(1, 1, 0));
    sram_ready = 1'b0; mem_access = 1'b1;
    step("sram_release", mk(1, 0, 0));
    idle_inputs();
    step("after_release", mk(0, 0, 0));

    // Flush priority: hazard blocks, then SRAM freeze blocks, RELEASE allows.
    load_use_on(); branch_taken = 1'b1;
    step("flush_blocked_hz", mk(1, 0, 0));
    idle_inputs(); branch_taken = 1'b1;
    step("flush", mk(0, 0, 1));
    mem_access = 1'b1;
    step("flush_blocked_sram", mk(0, 1, 0));
    idle_inputs(); sram_ready = 1'b1;
    step("flush_wait_ready", mk(0, 1, 0));
    idle_inputs(); branch_taken = 1'b1;
    step("flush_in_release", mk(0, 0, 1));
    idle_inputs();
    step("flush_idle", mk(0, 0, 0));
    check_perf("mid");

    // Timeout: 15 WAIT cycles, sticky flag, RELEASE, then the held access reissues.
    mem_access = 1'b1;
    step("to_issue", mk(0, 1, 0));
    for (int i = 0; i < 15; i++) step("to_wait", mk(0, 1, 0));
    exp_to = 1'b1;
    step("to_release", mk(0, 0, 0));
    step("to_reissue", mk(0, 1, 0));
    mem_access = 1'b0;
    step("to_wait_again", mk(0, 1, 0));

    // Reset in WAIT drops the request and the sticky timeout immediately.
    rst_n = 1'b0; exp_to = 1'b0;
    model_stall = 0; model_flush = 0;
    step("rst_in_wait", mk(0, 0, 0));
    rst_n = 1'b1;
    step("post_reset", mk(0, 0, 0));
    check_perf("end");

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
